// File: rtl/regfile_param_pkg.sv
// Shared defaults and address helpers for the parametrised register file.
`include "rf_defs.vh"

package regfile_param_pkg;

  localparam int RF_DEF_WIDTH    = `RF_DEF_WIDTH;
  localparam int RF_DEF_NUM_REGS = `RF_DEF_NUM_REGS;
  localparam int RF_DEF_NUM_RD   = `RF_DEF_NUM_RD;

  // A single-entry file still needs one address bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input int n);
    return addr < 32'(n);
  endfunction

endpackage

// File: rtl/rf_defs.vh
// Default register-file geometry shared by decode and the bench.
// RF_BYPASS_EN is deliberately left undefined here; define it on the command line for write-before-read.
`ifndef RF_DEFS_VH
`define RF_DEFS_VH

`define RF_DEF_WIDTH    16
`define RF_DEF_NUM_REGS 8
`define RF_DEF_NUM_RD   2

`endif

// File: rtl/rf_entry.sv
// One WIDTH-bit register with write enable and synchronous clear.
module rf_entry #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/regfile_param.sv
// NUM_REGS x WIDTH register file: NUM_RD async read ports, one sync write port, err flag.
// Optional write-to-read bypass under macro RF_BYPASS_EN (default: undefined, reads show old value).
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int  WIDTH    = RF_DEF_WIDTH,
  parameter int  NUM_REGS = RF_DEF_NUM_REGS,
  parameter int  NUM_RD   = RF_DEF_NUM_RD,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_en,
  input  logic [AW-1:0]           write_addr,
  input  logic [WIDTH-1:0]        write_data,
  input  logic [NUM_RD*AW-1:0]    read_addr,
  output logic [NUM_RD*WIDTH-1:0] read_data,
  output logic                    err
);

  logic [WIDTH-1:0]    entry_q [NUM_REGS];
  logic [NUM_REGS-1:0] entry_en;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    assign entry_en[i] = write_en & (write_addr == AW'(i)) & ~rst;

    rf_entry #(.WIDTH(WIDTH)) u_entry (
      .clk (clk),
      .rst (rst),
      .en  (entry_en[i]),
      .d   (write_data),
      .q   (entry_q[i])
    );
  end

`ifdef RF_BYPASS_EN
  logic write_ok;
  assign write_ok = write_en & ~rst & in_range(32'(write_addr), NUM_REGS);
`endif

  // Compare-per-entry mux: out-of-range addresses match nothing and read as zero.
  always_comb begin
    read_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (read_addr[p*AW +: AW] == AW'(i))
          read_data[p*WIDTH +: WIDTH] = entry_q[i];
      end
`ifdef RF_BYPASS_EN
      if (write_ok && (read_addr[p*AW +: AW] == write_addr))
        read_data[p*WIDTH +: WIDTH] = write_data;
`endif
    end
  end

  logic xz_ctrl;
  logic xz_write;
  logic bad_addr;

  assign xz_ctrl  = $isunknown({clk, rst, write_en, read_addr});
  assign xz_write = write_en & $isunknown({write_addr, write_data});
  assign bad_addr = write_en & ~in_range(32'(write_addr), NUM_REGS);
  assign err      = xz_ctrl | xz_write | bad_addr;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default, 6-entry and 4-port/32-bit instances against array reference models.
module tb_regfile_param;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int R  = 2;
  localparam int A  = 3;
  localparam int N6 = 6;
  localparam int W4 = 32;
  localparam int R4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic           we = 1'b0;
  logic [A-1:0]   wa = '0;
  logic [W-1:0]   wd = '0;
  logic [R*A-1:0] ra = '0;
  logic [R*W-1:0] rd;
  logic           err;

  logic           we6 = 1'b0;
  logic [A-1:0]   wa6 = '0;
  logic [W-1:0]   wd6 = '0;
  logic [R*A-1:0] ra6 = '0;
  logic [R*W-1:0] rd6;
  logic           err6;

  logic             we4 = 1'b0;
  logic [A-1:0]     wa4 = '0;
  logic [W4-1:0]    wd4 = '0;
  logic [R4*A-1:0]  ra4 = '0;
  logic [R4*W4-1:0] rd4;
  logic             err4;

  int n_cmp = 0;
  int n_bad = 0;
  bit four_state;

  logic [W-1:0]  model  [N];
  logic [W-1:0]  model6 [N6];
  logic [W4-1:0] model4 [N];

  regfile_param u_dut (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .read_addr(ra), .read_data(rd), .err(err)
  );

  regfile_param #(.NUM_REGS(N6)) u_dut6 (
    .clk(clk), .rst(rst), .write_en(we6), .write_addr(wa6), .write_data(wd6),
    .read_addr(ra6), .read_data(rd6), .err(err6)
  );

  regfile_param #(.WIDTH(W4), .NUM_RD(R4)) u_dut4 (
    .clk(clk), .rst(rst), .write_en(we4), .write_addr(wa4), .write_data(wd4),
    .read_addr(ra4), .read_data(rd4), .err(err4)
  );

  initial forever #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_models();
    for (int i = 0; i < N; i++) begin
      model[i]  = '0;
      model4[i] = '0;
    end
    for (int i = 0; i < N6; i++) model6[i] = '0;
  endtask

  task automatic check_all_main(input string tag);
    for (int i = 0; i < N; i++) begin
      ra = {A'(i), A'(i)};
      #1;
      for (int p = 0; p < R; p++) begin
        n_cmp++;
        if (rd[p*W +: W] !== model[i]) begin
          n_bad++;
          $display("FAIL %s entry %0d port %0d: got %h want %h", tag, i, p, rd[p*W +: W], model[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    clear_models();
    check_all_main("reset_init");
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b want 0", err);
    end
    for (int i = 0; i < N; i++) begin
      we = 1'b1; wa = A'(i); wd = 16'hFFFF;
      cyc();
      model[i] = 16'hFFFF;
    end
    rst = 1'b1; we = 1'b1; wa = 3'd2; wd = 16'h1234; ra = {3'd2, 3'd2};
    #1;
    n_cmp++;
    if (rd[0 +: W] !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL reset_no_bypass: got %h want ffff", rd[0 +: W]);
    end
    cyc();
    rst = 1'b0; we = 1'b0;
    clear_models();
    check_all_main("reset_clear");
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 3'd3; wd = 16'hA5A5;
    cyc();
    model[3] = 16'hA5A5;
    wa = 3'd7; wd = 16'h1234;
    cyc();
    model[7] = 16'h1234;
    we = 1'b0;
    ra = {3'd7, 3'd3};
    #1;
    n_cmp++;
    if (rd[0 +: W] !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL wr_port0: got %h want a5a5", rd[0 +: W]);
    end
    n_cmp++;
    if (rd[W +: W] !== 16'h1234) begin
      n_bad++;
      $display("FAIL wr_port1: got %h want 1234", rd[W +: W]);
    end
    check_all_main("wr_others");
  endtask

  task automatic test_collision();
    logic [W-1:0] exp;
    we = 1'b1; wa = 3'd5; wd = 16'h0001;
    cyc();
    model[5] = 16'h0001;
    wd = 16'h0002; ra = {3'd0, 3'd5};
    #1;
`ifdef RF_BYPASS_EN
    exp = 16'h0002;
`else
    exp = 16'h0001;
`endif
    n_cmp++;
    if (rd[0 +: W] !== exp) begin
      n_bad++;
      $display("FAIL collide_same_cycle: got %h want %h", rd[0 +: W], exp);
    end
    cyc();
    model[5] = 16'h0002;
    we = 1'b0;
    #1;
    n_cmp++;
    if (rd[0 +: W] !== 16'h0002) begin
      n_bad++;
      $display("FAIL collide_next_cycle: got %h want 0002", rd[0 +: W]);
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < N6; i++) begin
      we6 = 1'b1; wa6 = A'(i); wd6 = W'($urandom);
      cyc();
      model6[i] = wd6;
    end
    for (int k = 6; k < 8; k++) begin
      we6 = 1'b1; wa6 = A'(k); wd6 = 16'hBEEF;
      #1;
      n_cmp++;
      if (err6 !== 1'b1) begin
        n_bad++;
        $display("FAIL oor_err addr %0d: got %b want 1", k, err6);
      end
      cyc();
    end
    we6 = 1'b0;
    #1;
    n_cmp++;
    if (err6 !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_err_clear: got %b want 0", err6);
    end
    for (int i = 0; i < N6; i++) begin
      ra6 = {3'd0, A'(i)};
      #1;
      n_cmp++;
      if (rd6[0 +: W] !== model6[i]) begin
        n_bad++;
        $display("FAIL oor_entry %0d: got %h want %h", i, rd6[0 +: W], model6[i]);
      end
    end
    ra6 = {3'd7, 3'd6};
    #1;
    n_cmp++;
    if (rd6 !== '0) begin
      n_bad++;
      $display("FAIL oor_read: got %h want 0", rd6);
    end
  endtask

  task automatic test_xz();
    logic [A-1:0] xaddr;
    logic probe;
    probe = 1'bx;
    four_state = $isunknown(probe);
    we = 1'b0; wd = 'z;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL xz_wdata_idle: got %b want 0", err);
    end
    if (four_state) begin
      xaddr = 3'bx1x;
      wd = '0;
      ra[A +: A] = xaddr;
      #1;
      n_cmp++;
      if (err !== 1'b1) begin
        n_bad++;
        $display("FAIL xz_raddr: got %b want 1", err);
      end
      ra = '0;
      cyc();
      we = 1'b1; wa = 3'd1; wd = 'z;
      #1;
      n_cmp++;
      if (err !== 1'b1) begin
        n_bad++;
        $display("FAIL xz_wdata_active: got %b want 1", err);
      end
    end else begin
      $display("note: 2-state simulator, X/Z-raises-err checks skipped");
    end
    we = 1'b0; wd = '0; ra = '0;
    cyc();
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL xz_recover: got %b want 0", err);
    end
  endtask

  task automatic test_params();
    int s;
    int offs [R4] = '{0, 1, 3, 6};
    int addr;
    for (int it = 0; it < 30; it++) begin
      we4 = 1'b1; wa4 = A'($urandom_range(0, N-1)); wd4 = $urandom;
      cyc();
      model4[wa4] = wd4;
      we4 = 1'b0;
      s = $urandom_range(0, N-1);
      for (int p = 0; p < R4; p++) ra4[p*A +: A] = A'((s + offs[p]) % N);
      #1;
      for (int p = 0; p < R4; p++) begin
        addr = (s + offs[p]) % N;
        n_cmp++;
        if (rd4[p*W4 +: W4] !== model4[addr]) begin
          n_bad++;
          $display("FAIL params it %0d port %0d addr %0d: got %h want %h",
                   it, p, addr, rd4[p*W4 +: W4], model4[addr]);
        end
      end
    end
    n_cmp++;
    if (err4 !== 1'b0) begin
      n_bad++;
      $display("FAIL params_err: got %b want 0", err4);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    int addr;
    for (int it = 0; it < 60; it++) begin
      we = 1'($urandom_range(0, 1));
      wa = A'($urandom_range(0, N-1));
      wd = W'($urandom);
      ra = (R*A)'($urandom);
      #1;
      for (int p = 0; p < R; p++) begin
        addr = int'(ra[p*A +: A]);
        exp = model[addr];
`ifdef RF_BYPASS_EN
        if (we && (int'(wa) == addr)) exp = wd;
`endif
        n_cmp++;
        if (rd[p*W +: W] !== exp) begin
          n_bad++;
          $display("FAIL b2b it %0d port %0d addr %0d: got %h want %h", it, p, addr, rd[p*W +: W], exp);
        end
      end
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_err it %0d: got %b want 0", it, err);
      end
      cyc();
      if (we) model[wa] = wd;
    end
    we = 1'b0;
    check_all_main("b2b_final");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_collision();
    test_out_of_range();
    test_xz();
    test_params();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
